// File: rtl/banco_registros_mp_if.sv
// banco_registros_mp_if: write, read, debug and status signals of the register bank
interface banco_registros_mp_if #(
  parameter int NB_REGISTER = 32,
  parameter int NB_ADDR     = 5,
  parameter int N_READ      = 2
);
  logic                          i_wr_enable;
  logic [NB_ADDR-1:0]            i_w_addr;
  logic [NB_REGISTER-1:0]        i_w_data;
  logic [N_READ*NB_ADDR-1:0]     i_r_addr;
  logic [N_READ*NB_REGISTER-1:0] o_r_data;
  logic [NB_ADDR-1:0]            i_dbg_addr;
  logic [NB_REGISTER-1:0]        o_dbg_data;
  logic                          o_ready;
  logic                          o_wr_drop;
  modport master (
    output i_wr_enable, i_w_addr, i_w_data, i_r_addr, i_dbg_addr,
    input  o_r_data, o_dbg_data, o_ready, o_wr_drop
  );
  modport slave (
    input  i_wr_enable, i_w_addr, i_w_data, i_r_addr, i_dbg_addr,
    output o_r_data, o_dbg_data, o_ready, o_wr_drop
  );
endinterface

// File: rtl/banco_registros_mp.sv
// banco_registros_mp: multi-read-port register bank with sequential init, optional zero register and write bypass
module banco_registros_mp #(
  parameter int NB_REGISTER = 32,
  parameter int NB_ADDR     = 5,
  parameter int N_READ      = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  parameter int INIT_MODE   = 1
) (
  input logic i_clk,
  input logic i_reset_n,
  banco_registros_mp_if.slave bus
);
  localparam int DEPTH = 1 << NB_ADDR;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, next_state;
  logic [NB_ADDR:0] cnt;
  logic [NB_REGISTER-1:0] regs [DEPTH];
  logic [NB_REGISTER-1:0] init_val;
  logic run, we, wr_ok;
  logic [NB_ADDR-1:0] wa;
  logic [NB_REGISTER-1:0] wd;
  assign run      = state == RUN;
  assign we       = bus.i_wr_enable;
  assign wa       = bus.i_w_addr;
  assign wd       = bus.i_w_data;
  assign wr_ok    = run && we && !(ZERO_REG != 0 && wa == '0);
  assign init_val = INIT_MODE != 0 ? NB_REGISTER'(cnt[NB_ADDR-1:0]) : '0;
  assign bus.o_ready = run;
  always_comb begin
    next_state = state;
    if (state == INIT && cnt == (NB_ADDR+1)'(DEPTH - 1)) next_state = RUN;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= INIT;
      cnt           <= '0;
      bus.o_wr_drop <= 1'b0;
    end else begin
      state         <= next_state;
      cnt           <= run ? cnt : cnt + (NB_ADDR+1)'(1);
      bus.o_wr_drop <= we && !run;
    end
  end
  // No reset on the array: it is filled one entry per cycle so it can map to distributed RAM
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      if (!run) regs[cnt[NB_ADDR-1:0]] <= init_val;
      else if (wr_ok) regs[wa] <= wd;
    end
  end
  function automatic logic [NB_REGISTER-1:0] rd(input logic [NB_ADDR-1:0] a, input logic byp);
    return (!run || (ZERO_REG != 0 && a == '0)) ? '0 : (byp && we && wa == a) ? wd : regs[a];
  endfunction
  always_comb begin
    bus.o_r_data = '0;
    for (int k = 0; k < N_READ; k++)
      bus.o_r_data[k*NB_REGISTER +: NB_REGISTER] = rd(bus.i_r_addr[k*NB_ADDR +: NB_ADDR], BYPASS != 0);
  end
  assign bus.o_dbg_data = rd(bus.i_dbg_addr, 1'b0);
endmodule
